serial_addsub: RTL and testbench

Parametrised serial adder/subtractor, the successor to the fixed 8-bit, 1-bit-per-cycle serial adder.
- Operand width (WIDTH) and bits per cycle (DIGIT) are generic.
- A run-time mode selects add or subtract.
- Operands are accepted through a ready/valid input handshake; results are returned through a ready/valid output handshake with back-pressure.
- Carry-out and signed overflow flags are produced.
- Sits between the operand register file and the result FIFO in the arithmetic datapath.

---
 rtl/serial_addsub_pkg.sv | 26 ++
 rtl/serial_digit_adder.sv | 37 +++
 rtl/serial_addsub.sv | 147 ++++++++++++++
 tb/tb_serial_addsub.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_addsub_pkg.sv
// serial_addsub_pkg
//   Shared types and elaboration helpers for the serial adder/subtractor.
//   - state_t    : control FSM encoding (IDLE / ADD / DONE)
//   - calc_steps : number of digit-serial ADD cycles per operation
//   - calc_cw    : width of the step counter (never narrower than 1 bit)
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int calc_steps(input int width, input int digit);
    return width / digit;
  endfunction

  // A single-step configuration still needs a 1-bit counter so that the
  // register and its compare stay well formed.
  function automatic int calc_cw(input int steps);
    int c;
    c = $clog2(steps);
    return (c < 1) ? 1 : c;
  endfunction

endpackage

// File: rtl/serial_digit_adder.sv
// serial_digit_adder
//   Purely combinational DIGIT-bit ripple slice used once per ADD cycle.
//   Ports:
//     x, y   : DIGIT-bit addends (low digits of the operand shift registers)
//     cin    : carry into bit 0 (running carry of the serial operation)
//     s      : DIGIT-bit slice sum
//     cout   : carry out of the top bit
//     c_msb  : carry into the top bit; XOR with cout gives signed overflow
//              when this slice holds the operand MSB
module serial_digit_adder #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             c_msb
);

  // Ripple carry held in a single variable so the chain resolves inside one
  // block instead of through a self-referencing vector.
  logic c;

  always_comb begin
    s     = '0;
    c     = cin;
    c_msb = cin;
    for (int i = 0; i < DIGIT; i++) begin
      if (i == DIGIT - 1) c_msb = c;
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/serial_addsub.sv
// serial_addsub
//   Digit-serial adder/subtractor. Operands are taken through a ready/valid
//   handshake, reduced DIGIT bits per clock over STEPS cycles, and the result
//   is presented through a ready/valid handshake that honours back-pressure.
//   Ports:
//     clk, rst            : clock, asynchronous active-low reset
//     in_valid / in_ready : operand handshake (in_ready only in IDLE)
//     a, b, sub           : operands and mode (0 = a+b, 1 = a-b)
//     out_valid/out_ready : result handshake (out_valid only in DONE)
//     sum, cout, ovf      : result, carry-out (no-borrow on subtract), signed
//                           overflow
//     busy                : high while the serial add is running
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int STEPS = calc_steps(WIDTH, DIGIT);
  localparam int CW    = calc_cw(STEPS);

  generate
    if (DIGIT < 1 || WIDTH < 2 || (WIDTH % DIGIT) != 0) begin : g_bad_param
      $error("serial_addsub: need WIDTH >= 2, DIGIT >= 1 and WIDTH %% DIGIT == 0");
    end
  endgenerate

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic [WIDTH-1:0] sum_nxt;
  logic [CW-1:0]    count;
  logic             carry;
  logic             last;

  logic [DIGIT-1:0] sl_s;
  logic             sl_cout;
  logic             sl_cmsb;

  assign last = (count == CW'(STEPS - 1));

  serial_digit_adder #(.DIGIT(DIGIT)) u_slice (
    .x     (a_reg[DIGIT-1:0]),
    .y     (b_reg[DIGIT-1:0]),
    .cin   (carry),
    .s     (sl_s),
    .cout  (sl_cout),
    .c_msb (sl_cmsb)
  );

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // FSM: next state. DONE always returns to IDLE first, so a new operand is
  // never accepted in the same cycle a result is consumed.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = ADD;
      ADD:     if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // FSM: outputs decoded purely from state
  always_comb begin
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE:    in_ready  = 1'b1;
      ADD:     busy      = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------
  // The result fills from the top: after STEPS shifts the first slice has
  // travelled down to the least significant digit.
  always_comb begin
    sum_nxt                    = sum >> DIGIT;
    sum_nxt[WIDTH-1 -: DIGIT]  = sl_s;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_reg <= '0;
      b_reg <= '0;
      sum   <= '0;
      count <= '0;
      carry <= 1'b0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            // Subtract as a + ~b + 1: invert b here and seed the carry.
            a_reg <= a;
            b_reg <= sub ? ~b : b;
            carry <= sub;
            count <= '0;
            sum   <= '0;
          end
        end
        ADD: begin
          sum   <= sum_nxt;
          a_reg <= a_reg >> DIGIT;
          b_reg <= b_reg >> DIGIT;
          carry <= sl_cout;
          count <= count + 1'b1;
          if (last) begin
            // The final slice holds the operand MSB, so its carries give
            // both the unsigned carry and the signed overflow.
            cout <= sl_cout;
            ovf  <= sl_cout ^ sl_cmsb;
          end
        end
        default: ;  // DONE holds everything stable for back-pressure
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub
//   Two instances: 8-bit/1-digit and 16-bit/4-digit. A scoreboard fed by a
//   plain-arithmetic model checks every result the DUTs present; directed
//   vectors pin literal results, latency, back-pressure and reset.
module tb_serial_addsub;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        iv[2], ordy[2], sb[2];
  logic [15:0] av[2], bv[2];
  logic        ir[2], ov[2], bsy[2], co[2], vf[2];
  logic [7:0]  s8;
  logic [15:0] s16;
  logic [15:0] ds[2];

  assign ds[0] = {8'h00, s8};
  assign ds[1] = s16;

  serial_addsub #(.WIDTH(8), .DIGIT(1)) u8 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
    .a(av[0][7:0]), .b(bv[0][7:0]), .sub(sb[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]),
    .sum(s8), .cout(co[0]), .ovf(vf[0]), .busy(bsy[0])
  );

  serial_addsub #(.WIDTH(16), .DIGIT(4)) u16 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
    .a(av[1]), .b(bv[1]), .sub(sb[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]),
    .sum(s16), .cout(co[1]), .ovf(vf[1]), .busy(bsy[1])
  );

  typedef struct {
    logic [15:0] s;
    logic        c;
    logic        v;
  } res_t;

  res_t q[2][$];
  int   errors = 0;
  int   checks = 0;

  function automatic int wd(input int i);
    return (i == 0) ? 8 : 16;
  endfunction

  function automatic int steps(input int i);
    return (i == 0) ? 8 : 4;
  endfunction

  // Reference: modulo-2^w arithmetic with the carry taken from bit w and
  // signed overflow from the operand/result signs.
  function automatic res_t model(input int w, input logic [15:0] a, b,
                                 input logic s);
    logic [16:0] m, aa, bb, full;
    res_t r;
    m    = (17'd1 << w) - 17'd1;
    aa   = {1'b0, a} & m;
    bb   = s ? (~{1'b0, b} & m) : ({1'b0, b} & m);
    full = aa + bb + {16'd0, s};
    r.s  = full[15:0] & m[15:0];
    r.c  = full[w];
    r.v  = (aa[w-1] == bb[w-1]) && (r.s[w-1] != aa[w-1]);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard: push on accept, compare every cycle a result is presented,
  // pop on the output handshake, flush on reset.
  task automatic compare_loop();
    res_t r;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (!rst) begin
          q[i].delete();
          continue;
        end
        chk("onehot_state", 32'($countones({ir[i], bsy[i], ov[i]})), 32'd1);
        if (ov[i]) begin
          if (q[i].size() == 0) begin
            chk("unexpected_result", 32'd1, 32'd0);
          end else begin
            chk("sb_sum",  32'(ds[i]), 32'(q[i][0].s));
            chk("sb_cout", 32'(co[i]), 32'(q[i][0].c));
            chk("sb_ovf",  32'(vf[i]), 32'(q[i][0].v));
            if (ordy[i]) void'(q[i].pop_front());
          end
        end
        if (iv[i] && ir[i]) begin
          r = model(wd(i), av[i], bv[i], sb[i]);
          q[i].push_back(r);
        end
      end
    end
  endtask

  // One operation: accept, optional operand scramble during ADD, latency
  // check, `hold` cycles of back-pressure with a competing in_valid, release.
  task automatic do_op(input int i, input logic [15:0] a, b, input logic s,
                       input int hold, input bit scr, output res_t r);
    int n;
    @(posedge clk); #1;
    av[i] = a; bv[i] = b; sb[i] = s; iv[i] = 1'b1; ordy[i] = 1'b0;
    n = 0;
    while (!ir[i] && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("accept_ready", 32'(ir[i]), 32'd1);
    @(posedge clk); #1;                       // accept edge
    iv[i] = 1'b0;
    if (scr) begin
      av[i] = ~a; bv[i] = b ^ 16'h5A5A; sb[i] = ~s;
    end
    n = 1;
    while (!ov[i] && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("latency", 32'(n), 32'(steps(i) + 1));
    r.s = ds[i]; r.c = co[i]; r.v = vf[i];
    for (int k = 0; k < hold; k++) begin
      iv[i] = 1'b1; av[i] = 16'h1234; bv[i] = 16'h4321;
      @(posedge clk); #1;
      chk("bp_sum",      32'(ds[i]), 32'(r.s));
      chk("bp_valid",    32'(ov[i]), 32'd1);
      chk("bp_in_ready", 32'(ir[i]), 32'd0);
    end
    iv[i] = 1'b0;
    ordy[i] = 1'b1;
    @(posedge clk); #1;
    ordy[i] = 1'b0;
    chk("release_in_ready",  32'(ir[i]), 32'd1);
    chk("release_out_valid", 32'(ov[i]), 32'd0);
  endtask

  task automatic expect_res(input string nm, input res_t r,
                            input logic [15:0] s, input logic c, v);
    chk({nm, "_sum"},  32'(r.s), 32'(s));
    chk({nm, "_cout"}, 32'(r.c), 32'(c));
    chk({nm, "_ovf"},  32'(r.v), 32'(v));
  endtask

  initial begin
    res_t r;
    logic [15:0] ra, rb;
    for (int i = 0; i < 2; i++) begin
      iv[i] = 1'b0; ordy[i] = 1'b0; sb[i] = 1'b0; av[i] = '0; bv[i] = '0;
    end
    fork
      compare_loop();
      begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
      end
    join_none

    // Reset state
    #2;
    for (int i = 0; i < 2; i++) begin
      chk("rst_in_ready",  32'(ir[i]),  32'd1);
      chk("rst_out_valid", 32'(ov[i]),  32'd0);
      chk("rst_busy",      32'(bsy[i]), 32'd0);
      chk("rst_sum",       32'(ds[i]),  32'd0);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Model pinned to hand-computed values
    expect_res("model_add8",  model(8, 16'h5A, 16'h3C, 1'b0), 16'h96, 1'b0, 1'b1);
    expect_res("model_sub16", model(16, 16'h8000, 16'h0001, 1'b1), 16'h7FFF, 1'b1, 1'b1);

    // 8-bit directed
    do_op(0, 16'h5A, 16'h3C, 1'b0, 0, 1'b0, r); expect_res("add_5a_3c", r, 16'h96, 1'b0, 1'b1);
    do_op(0, 16'h10, 16'h20, 1'b1, 0, 1'b0, r); expect_res("sub_10_20", r, 16'hF0, 1'b0, 1'b0);
    do_op(0, 16'h80, 16'h01, 1'b1, 0, 1'b0, r); expect_res("sub_80_01", r, 16'h7F, 1'b1, 1'b1);
    do_op(0, 16'hFF, 16'h01, 1'b0, 0, 1'b1, r); expect_res("wrap_scr",  r, 16'h00, 1'b1, 1'b0);
    do_op(0, 16'h44, 16'h22, 1'b0, 5, 1'b0, r); expect_res("backpress", r, 16'h66, 1'b0, 1'b0);

    // Reset at ADD step 4 aborts the operation
    @(posedge clk); #1;
    av[0] = 16'h33; bv[0] = 16'h11; sb[0] = 1'b0; iv[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_busy", 32'(bsy[0]), 32'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_in_ready",  32'(ir[0]),  32'd1);
    chk("mid_rst_out_valid", 32'(ov[0]),  32'd0);
    chk("mid_rst_busy",      32'(bsy[0]), 32'd0);
    chk("mid_rst_sum",       32'(ds[0]),  32'd0);
    chk("mid_rst_cout",      32'(co[0]),  32'd0);
    chk("mid_rst_ovf",       32'(vf[0]),  32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("abort_no_result", 32'(ov[0]), 32'd0);
    do_op(0, 16'h01, 16'h01, 1'b0, 0, 1'b0, r); expect_res("post_rst", r, 16'h02, 1'b0, 1'b0);

    // 16-bit, 4-bit digits
    do_op(1, 16'h7FFF, 16'h0001, 1'b0, 0, 1'b0, r); expect_res("w16_add", r, 16'h8000, 1'b0, 1'b1);
    do_op(1, 16'h0000, 16'h0001, 1'b1, 0, 1'b0, r); expect_res("w16_sub0", r, 16'hFFFF, 1'b0, 1'b0);
    do_op(1, 16'h8000, 16'h0001, 1'b1, 2, 1'b1, r); expect_res("w16_sub8", r, 16'h7FFF, 1'b1, 1'b1);

    // Random sweeps; results checked by the scoreboard
    for (int n = 0; n < 1000; n++) begin
      ra = 16'($urandom); rb = 16'($urandom);
      do_op(1, ra, rb, 1'($urandom), $urandom_range(0, 2), 1'($urandom), r);
    end
    for (int n = 0; n < 200; n++) begin
      ra = 16'($urandom_range(0, 255)); rb = 16'($urandom_range(0, 255));
      do_op(0, ra, rb, 1'($urandom), $urandom_range(0, 1), 1'($urandom), r);
    end

    repeat (3) @(posedge clk);
    chk("sb_drained0", 32'(q[0].size()), 32'd0);
    chk("sb_drained1", 32'(q[1].size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
